// File: rtl/vga_text_pkg.sv
// Shared constants, FSM state encoding and buffer addressing for the text-mode VGA controller.
// Latency: none (package only).
// Backpressure: none (package only).
package vga_text_pkg;
    localparam int COLS   = 70;
    localparam int ROWS   = 30;
    localparam int CELL_W = 9;
    localparam int CELL_H = 16;
    localparam int DEPTH  = COLS * ROWS;
    localparam int AW     = $clog2(DEPTH);

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] TILDE = 8'h7E;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] CR    = 8'h0D;

    typedef enum logic [1:0] {
        INIT_CLR = 2'd0,
        IDLE     = 2'd1,
        ROW_CLR  = 2'd2
    } state_t;

    function automatic logic [AW-1:0] cell_addr(input logic [6:0] x, input logic [4:0] y);
        return AW'(y) * AW'(COLS) + AW'(x);
    endfunction
endpackage

// File: rtl/text_ram.sv
// Character buffer: one synchronous read port, one write port; a colliding read returns the old byte.
// Latency: read data 1 cycle after rd_addr; writes land on the same edge.
// Backpressure: none, both ports accept every cycle.
module text_ram
    import vga_text_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_dat,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_dat
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat <= SPACE;
        end else begin
            rd_dat <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/vga_text_ctrl.sv
// Text-mode VGA controller: 70x30 character buffer fed by a char stream, rendered through an external font ROM.
// Latency: pixel colour 2 cycles after h_addr/v_addr/pix_valid; cursor moves 1 cycle after a handshake.
// Backpressure: chr_ready low while the whole buffer or a newly entered row is being cleared.
module vga_text_ctrl
    import vga_text_pkg::*;
#(
    parameter int          BLINK_HALF = 12_500_000,
    parameter logic [23:0] FG         = 24'hFFFFFF,
    parameter logic [23:0] BG         = 24'h000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  h_addr,
    input  logic [9:0]  v_addr,
    input  logic        pix_valid,
    output logic [7:0]  rom_ascii,
    output logic [3:0]  rom_row,
    output logic [3:0]  rom_col,
    input  logic        rom_data,
    output logic [23:0] vga_data,
    output logic        vga_data_valid,
    input  logic        chr_valid,
    input  logic [7:0]  chr_data,
    output logic        chr_ready,
    output logic [6:0]  cursor_x,
    output logic [4:0]  cursor_y
);
    localparam int BW = $clog2(BLINK_HALF + 1);

    state_t        state, state_nxt;
    logic [AW-1:0] clr_cnt, clr_cnt_nxt;
    logic [6:0]    cur_x_nxt;
    logic [4:0]    cur_y_nxt, y_inc;
    logic          wr_en;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [7:0]    wr_dat;

    assign chr_ready = (state == IDLE);
    assign y_inc     = (cursor_y == 5'(ROWS - 1)) ? 5'd0 : cursor_y + 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT_CLR;
            clr_cnt  <= '0;
            cursor_x <= '0;
            cursor_y <= '0;
        end else begin
            state    <= state_nxt;
            clr_cnt  <= clr_cnt_nxt;
            cursor_x <= cur_x_nxt;
            cursor_y <= cur_y_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        cur_x_nxt   = cursor_x;
        cur_y_nxt   = cursor_y;
        wr_en       = 1'b0;
        wr_addr     = clr_cnt;
        wr_dat      = SPACE;
        case (state)
            INIT_CLR: begin
                wr_en       = 1'b1;
                clr_cnt_nxt = clr_cnt + AW'(1);
                if (clr_cnt == AW'(DEPTH - 1)) begin
                    state_nxt   = IDLE;
                    clr_cnt_nxt = '0;
                end
            end
            ROW_CLR: begin
                // cursor_y already points at the row being entered
                wr_en       = 1'b1;
                wr_addr     = cell_addr(clr_cnt[6:0], cursor_y);
                clr_cnt_nxt = clr_cnt + AW'(1);
                if (clr_cnt == AW'(COLS - 1)) begin
                    state_nxt   = IDLE;
                    clr_cnt_nxt = '0;
                end
            end
            IDLE: begin
                if (chr_valid) begin
                    if (chr_data >= SPACE && chr_data <= TILDE) begin
                        wr_en   = 1'b1;
                        wr_addr = cell_addr(cursor_x, cursor_y);
                        wr_dat  = chr_data;
                        if (cursor_x == 7'(COLS - 1)) begin
                            cur_x_nxt = '0;
                            cur_y_nxt = y_inc;
                            state_nxt = ROW_CLR;
                        end else begin
                            cur_x_nxt = cursor_x + 7'd1;
                        end
                    end else if (chr_data == LF || chr_data == CR) begin
                        cur_x_nxt = '0;
                        cur_y_nxt = y_inc;
                        state_nxt = ROW_CLR;
                    end else if (chr_data == BS && (cursor_x != '0 || cursor_y != '0)) begin
                        if (cursor_x == '0) begin
                            cur_x_nxt = 7'(COLS - 1);
                            cur_y_nxt = cursor_y - 5'd1;
                        end else begin
                            cur_x_nxt = cursor_x - 7'd1;
                        end
                        wr_en   = 1'b1;
                        wr_addr = cell_addr(cur_x_nxt, cur_y_nxt);
                    end
                end
            end
            default: state_nxt = INIT_CLR;
        endcase
    end

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    logic [9:0] cx;
    logic [5:0] cy;
    logic [3:0] px, py;
    logic       in_rng, hit;

    assign cx      = h_addr / 10'(CELL_W);
    assign px      = 4'(h_addr % 10'(CELL_W));
    assign cy      = v_addr[9:4];
    assign py      = v_addr[3:0];
    assign in_rng  = (cx < 10'(COLS)) && (cy < 6'(ROWS));
    assign hit     = blink_phase && in_rng && (cx[6:0] == cursor_x) && (cy[4:0] == cursor_y)
                     && (py >= 4'(CELL_H - 2));
    // off-screen cells still read a legal address; their colour is forced to BG later
    assign rd_addr = in_rng ? cell_addr(cx[6:0], cy[4:0]) : '0;

    text_ram u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_addr (rd_addr),
        .rd_dat  (rom_ascii),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_dat  (wr_dat)
    );

    logic s1_vld, s1_rng, s1_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_row        <= '0;
            rom_col        <= '0;
            s1_vld         <= 1'b0;
            s1_rng         <= 1'b0;
            s1_hit         <= 1'b0;
            vga_data       <= '0;
            vga_data_valid <= 1'b0;
        end else begin
            rom_row        <= py;
            rom_col        <= px;
            s1_vld         <= pix_valid;
            s1_rng         <= in_rng;
            s1_hit         <= hit;
            vga_data_valid <= s1_vld;
            if (!s1_vld) begin
                vga_data <= '0;
            end else if (s1_rng && (s1_hit || rom_data)) begin
                vga_data <= FG;
            end else begin
                vga_data <= BG;
            end
        end
    end
endmodule

// File: tb/tb_vga_text_ctrl.sv
// Directed bench for vga_text_ctrl: stimulus pushes expectations into queues, monitors pop and compare.
// Font ROM is modelled as a fixed bit-pick of the character code.
module tb_vga_text_ctrl;
    localparam int          BH = 64;
    localparam logic [23:0] FG = 24'hFFFFFF;
    localparam logic [23:0] BG = 24'h000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  h_addr, v_addr;
    logic        pix_valid;
    logic [7:0]  rom_ascii;
    logic [3:0]  rom_row, rom_col;
    logic        rom_data;
    logic [23:0] vga_data;
    logic        vga_data_valid;
    logic        chr_valid;
    logic [7:0]  chr_data;
    logic        chr_ready;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;

    always #5 clk = ~clk;

    vga_text_ctrl #(.BLINK_HALF(BH), .FG(FG), .BG(BG)) dut (
        .clk(clk), .rst_n(rst_n), .h_addr(h_addr), .v_addr(v_addr), .pix_valid(pix_valid),
        .rom_ascii(rom_ascii), .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data),
        .vga_data(vga_data), .vga_data_valid(vga_data_valid),
        .chr_valid(chr_valid), .chr_data(chr_data), .chr_ready(chr_ready),
        .cursor_x(cursor_x), .cursor_y(cursor_y)
    );

    function automatic logic glyph(input logic [7:0] a, input logic [3:0] r, input logic [3:0] c);
        logic [3:0] s;
        s = r + c;
        return (a != 8'h20) && a[s[2:0]];
    endfunction

    assign rom_data = glyph(rom_ascii, rom_row, rom_col);

    typedef struct packed { logic chk; logic [7:0] asc; logic [3:0] row; logic [3:0] col; } rom_exp_t;
    typedef struct packed { logic [23:0] dat; logic vld; } pix_exp_t;
    typedef struct packed { logic [6:0] x; logic [4:0] y; } cur_exp_t;

    rom_exp_t rq[$];
    pix_exp_t pq[$];
    cur_exp_t cq[$];

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;
    logic iss = 1'b0, iss_d1 = 1'b0, iss_d2 = 1'b0, hs_d = 1'b0;
    logic [6:0] cur_x = '0;
    logic [4:0] cur_y = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ncyc <= 0;
        else        ncyc <= ncyc + 1;
    end

    always @(posedge clk) begin
        iss_d1 <= iss;
        iss_d2 <= iss_d1;
        hs_d   <= chr_valid && chr_ready;
    end

    always @(negedge clk) begin
        rom_exp_t re;
        pix_exp_t pe;
        cur_exp_t ce;
        if (iss_d1) begin
            if (rq.size() == 0) chk("rom_queue_underflow", 1, 0);
            else begin
                re = rq.pop_front();
                if (re.chk) begin
                    chk("rom_ascii", 32'(rom_ascii), 32'(re.asc));
                    chk("rom_row", 32'(rom_row), 32'(re.row));
                    chk("rom_col", 32'(rom_col), 32'(re.col));
                end
            end
        end
        if (iss_d2) begin
            if (pq.size() == 0) chk("pix_queue_underflow", 1, 0);
            else begin
                pe = pq.pop_front();
                chk("vga_data", 32'(vga_data), 32'(pe.dat));
                chk("vga_data_valid", 32'(vga_data_valid), 32'(pe.vld));
            end
        end
        if (hs_d) begin
            if (cq.size() == 0) chk("cursor_queue_underflow", 1, 0);
            else begin
                ce = cq.pop_front();
                chk("cursor_x", 32'(cursor_x), 32'(ce.x));
                chk("cursor_y", 32'(cursor_y), 32'(ce.y));
            end
        end
    end

    task automatic drive(input int h, input int v, input logic pv, input logic [7:0] asc);
        int cxi, cyi, pxi, pyi;
        logic rng, ph, hit;
        rom_exp_t re;
        pix_exp_t pe;
        cxi = h / 9;  pxi = h % 9;
        cyi = v / 16; pyi = v % 16;
        rng = (cxi < 70) && (cyi < 30);
        ph  = ((ncyc / BH) % 2) == 1;
        hit = ph && rng && (cxi == int'(cur_x)) && (cyi == int'(cur_y)) && (pyi >= 14);
        re.chk = rng; re.asc = asc; re.row = 4'(pyi); re.col = 4'(pxi);
        pe.vld = pv;
        if (!pv)                                     pe.dat = '0;
        else if (!rng)                               pe.dat = BG;
        else if (hit || glyph(asc, 4'(pyi), 4'(pxi))) pe.dat = FG;
        else                                         pe.dat = BG;
        rq.push_back(re);
        pq.push_back(pe);
        h_addr = 10'(h); v_addr = 10'(v); pix_valid = pv; iss = 1'b1;
        @(posedge clk); #1;
        iss = 1'b0;
    endtask

    task automatic send(input logic [7:0] c, input int ex, input int ey, input int exp_stall);
        int n;
        cur_exp_t ce;
        ce.x = 7'(ex); ce.y = 5'(ey);
        cq.push_back(ce);
        chr_valid = 1'b1; chr_data = c;
        n = 0;
        while (!chr_ready && n < 5000) begin @(posedge clk); #1; n++; end
        if (!chr_ready) chk("send_ready_timeout", 1, 0);
        @(posedge clk); #1;
        chr_valid = 1'b0;
        cur_x = 7'(ex); cur_y = 5'(ey);
        n = 0;
        while (!chr_ready && n < 200) begin @(posedge clk); #1; n++; end
        chk("ready_stall_cycles", 32'(n), 32'(exp_stall));
    endtask

    task automatic do_reset();
        int n;
        rst_n = 1'b0; chr_valid = 1'b0; chr_data = '0;
        pix_valid = 1'b0; h_addr = '0; v_addr = '0; iss = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_chr_ready", 32'(chr_ready), 0);
        chk("rst_cursor_x", 32'(cursor_x), 0);
        chk("rst_cursor_y", 32'(cursor_y), 0);
        chk("rst_rom_ascii", 32'(rom_ascii), 32'h20);
        chk("rst_rom_row", 32'(rom_row), 0);
        chk("rst_rom_col", 32'(rom_col), 0);
        chk("rst_vga_data", 32'(vga_data), 0);
        chk("rst_vga_valid", 32'(vga_data_valid), 0);
        cur_x = '0; cur_y = '0;
        rst_n = 1'b1;
        n = 0;
        while (!chr_ready && n < 3000) begin @(posedge clk); #1; n++; end
        chk("init_clr_cycles", 32'(n), 2100);
    endtask

    task automatic scan_row(input int cy, input int py, input logic [7:0] base, input int span);
        for (int c = 0; c < 70; c++) begin
            drive(c * 9 + (c % 9), cy * 16 + py, 1'b1,
                  (span == 0) ? 8'h20 : base + 8'(c % span));
        end
    endtask

    initial begin
        do_reset();

        // blink overlay on the home cell: spans both phases
        for (int i = 0; i < 2 * BH + 8; i++) drive(2, 15, 1'b1, 8'h20);
        for (int i = 0; i < 4; i++) drive(2, 13, 1'b1, 8'h20);

        // sparse full-frame sweep, including off-screen column and row
        for (int cy = 0; cy < 30; cy++) begin
            for (int cx = 0; cx < 70; cx++) drive(cx * 9 + (cx % 9), cy * 16 + 14 + (cx % 2), 1'b1, 8'h20);
            drive(630 + (cy % 10), cy * 16 + 3, 1'b1, 8'h20);
        end
        drive(4, 480, 1'b1, 8'h20);

        send(8'h41, 1, 0, 0);
        for (int v = 0; v < 16; v++)
            for (int h = 0; h < 9; h++) drive(h, v, 1'b1, 8'h41);

        send(8'h08, 0, 0, 0);
        drive(4, 7, 1'b1, 8'h20);

        for (int i = 0; i < 70; i++) begin
            if (i < 69) send(8'h30 + 8'(i % 40), i + 1, 0, 0);
            else        send(8'h30 + 8'(i % 40), 0, 1, 70);
        end
        scan_row(0, 5, 8'h30, 40);
        scan_row(1, 9, 8'h20, 0);

        send(8'h08, 69, 0, 0);
        drive(69 * 9 + 2, 6, 1'b1, 8'h20);
        drive(68 * 9 + 2, 6, 1'b1, 8'h4C);

        send(8'h0A, 0, 1, 70);
        for (int k = 1; k <= 28; k++) send(8'h0A, 0, 1 + k, 70);
        send(8'h0A, 0, 0, 70);
        scan_row(0, 4, 8'h20, 0);
        send(8'h08, 0, 0, 0);
        send(8'h01, 0, 0, 0);
        send(8'h0D, 0, 1, 70);

        drive(635, 10, 1'b1, 8'h20);
        drive(635, 10, 1'b0, 8'h20);
        drive(639, 479, 1'b1, 8'h20);
        drive(3, 20, 1'b0, 8'h20);

        for (int i = 0; i < 2 * BH + 8; i++) drive(4, 30, 1'b1, 8'h20);
        for (int i = 0; i < 4; i++) drive(4, 29, 1'b1, 8'h20);

        // reset in the middle of a row clear must restart the full buffer clear
        begin
            cur_exp_t ce;
            ce.x = 7'd0; ce.y = 5'd2;
            cq.push_back(ce);
            chr_valid = 1'b1; chr_data = 8'h0A;
            @(posedge clk); #1;
            chr_valid = 1'b0;
            repeat (10) begin @(posedge clk); #1; end
            chk("row_clr_ready_low", 32'(chr_ready), 0);
        end
        do_reset();

        repeat (4) begin @(posedge clk); #1; end
        chk("queues_drained", 32'(rq.size() + pq.size() + cq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
